uart_receiver: RTL and testbench



---
 rtl/uart_receiver.sv | 172 +++++++++++++++++
 tb/tb_uart_receiver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop input synchroniser, mid-bit sampling of an
// 8N1 / 8E1 frame, and a single registered outcome pulse per completed frame.
module uart_receiver #(
    parameter int clock_freq = 50_000_000,
    parameter int baud       = 9600,
    parameter bit parity_en  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       receive_wire,
    input  logic       fifo_full,
    output logic [7:0] data_out,
    output logic       fifo_write,
    output logic       parity_error,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       state_busy
);

    localparam int cycles_per_bit = clock_freq / baud;
    localparam int cnt_w          = $clog2(cycles_per_bit) + 1;

    localparam logic [cnt_w-1:0] bit_last  = cnt_w'(cycles_per_bit - 1);
    localparam logic [cnt_w-1:0] half_last = cnt_w'(cycles_per_bit / 2 - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [2:0]       state_q, state_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             fifo_write_q, fifo_write_d;
    logic             parity_error_q, parity_error_d;
    logic             framing_error_q, framing_error_d;
    logic             overrun_error_q, overrun_error_d;

    logic rx_s;
    logic bit_done;

    assign rx_s     = sync2_q;
    assign bit_done = (cnt_q == bit_last);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        sync1_d         = receive_wire;
        sync2_d         = sync1_q;
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        parity_d        = parity_q;
        data_out_d      = data_out_q;
        fifo_write_d    = 1'b0;
        parity_error_d  = 1'b0;
        framing_error_d = 1'b0;
        overrun_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == half_last) begin
                    cnt_d = '0;
                    // A start bit that has gone high again by mid-bit was noise.
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_w'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = parity_en ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_w'(1);
                end
            end
            PARITY: begin
                if (bit_done) begin
                    cnt_d    = '0;
                    parity_d = rx_s;
                    state_d  = STOP;
                end else begin
                    cnt_d = cnt_q + cnt_w'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    // Leave mid stop bit so a back-to-back start edge is caught.
                    cnt_d      = '0;
                    state_d    = IDLE;
                    data_out_d = shift_q;
                    if (!rx_s) begin
                        framing_error_d = 1'b1;
                    end else if (parity_en && ((^shift_q) ^ parity_q)) begin
                        parity_error_d = 1'b1;
                    end else if (fifo_full) begin
                        overrun_error_d = 1'b1;
                    end else begin
                        fifo_write_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_w'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            state_q         <= IDLE;
            cnt_q           <= '0;
            bit_idx_q       <= 3'd0;
            shift_q         <= 8'h00;
            parity_q        <= 1'b0;
            data_out_q      <= 8'h00;
            fifo_write_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            parity_q        <= parity_d;
            data_out_q      <= data_out_d;
            fifo_write_q    <= fifo_write_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
            overrun_error_q <= overrun_error_d;
        end
    end

    assign data_out      = data_out_q;
    assign fifo_write    = fifo_write_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign overrun_error = overrun_error_q;
    assign state_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 10 clocks per bit, one instance with even
// parity and one without; outcome pulses are tallied by per-instance monitors.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line1 = 1'b1;
    logic       line0 = 1'b1;
    logic       fifo_full = 1'b0;

    logic [7:0] data_out1, data_out0;
    logic       wr1, perr1, ferr1, oerr1, busy1;
    logic       wr0, perr0, ferr0, oerr0, busy0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int wr_cnt1 = 0, perr_cnt1 = 0, ferr_cnt1 = 0, oerr_cnt1 = 0, multi1 = 0;
    int wr_cyc1 = 0;
    logic [7:0] last_wr1 = 8'h00;
    int wr_cnt0 = 0, err_cnt0 = 0, wr_cyc0 = 0;
    logic [7:0] last_wr0 = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    uart_receiver #(.clock_freq(1_000_000), .baud(100_000), .parity_en(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .receive_wire(line1), .fifo_full(fifo_full),
        .data_out(data_out1), .fifo_write(wr1), .parity_error(perr1),
        .framing_error(ferr1), .overrun_error(oerr1), .state_busy(busy1)
    );

    uart_receiver #(.clock_freq(1_000_000), .baud(100_000), .parity_en(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .receive_wire(line0), .fifo_full(1'b0),
        .data_out(data_out0), .fifo_write(wr0), .parity_error(perr0),
        .framing_error(ferr0), .overrun_error(oerr0), .state_busy(busy0)
    );

    always @(negedge clk) begin
        if (wr1) begin wr_cnt1++; last_wr1 = data_out1; wr_cyc1 = cyc; end
        if (perr1) perr_cnt1++;
        if (ferr1) ferr_cnt1++;
        if (oerr1) oerr_cnt1++;
        if ((int'(wr1) + int'(perr1) + int'(ferr1) + int'(oerr1)) > 1) multi1++;
        if (wr0) begin wr_cnt0++; last_wr0 = data_out0; wr_cyc0 = cyc; end
        if (perr0 || ferr0 || oerr0) err_cnt0++;
    end

    initial begin
        #1ms;
        $display("FAIL timeout: bench did not finish within 1ms (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame on the parity-enabled line; returns the cycle of the start edge.
    task automatic send1(input logic [7:0] d, input logic par, input logic stop, output int start_cyc);
        start_cyc = cyc;
        line1 = 1'b0; hold(10);
        for (int i = 0; i < 8; i++) begin line1 = d[i]; hold(10); end
        line1 = par;  hold(10);
        line1 = stop; hold(10);
        line1 = 1'b1;
    endtask

    task automatic test_reset;
        hold(3);
        if (data_out1 !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h want 00", data_out1); end
        checks++;
        if ({wr1, perr1, ferr1, oerr1} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b want 0000", {wr1, perr1, ferr1, oerr1}); end
        checks++;
        if ({busy1, busy0} !== 2'b00) begin errors++; $display("FAIL reset_busy got %b want 00", {busy1, busy0}); end
        checks++;
        rst_n = 1'b1;
        hold(5);
        if (busy1 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy1); end
        checks++;
    endtask

    task automatic test_good_frame;
        int s;
        send1(8'hA5, 1'b0, 1'b1, s);
        if (busy1 !== 1'b0) begin errors++; $display("FAIL good_busy_fall got %b want 0", busy1); end
        checks++;
        hold(20);
        if (wr_cnt1 !== 1 || last_wr1 !== 8'hA5) begin errors++; $display("FAIL good_write got cnt=%0d data=%h want cnt=1 data=a5", wr_cnt1, last_wr1); end
        checks++;
        if (perr_cnt1 + ferr_cnt1 + oerr_cnt1 !== 0) begin errors++; $display("FAIL good_no_errors got %0d want 0", perr_cnt1 + ferr_cnt1 + oerr_cnt1); end
        checks++;
        if (wr_cyc1 - s < 106 || wr_cyc1 - s > 109) begin errors++; $display("FAIL good_latency got %0d want 106..109", wr_cyc1 - s); end
        checks++;
        if (data_out1 !== 8'hA5) begin errors++; $display("FAIL good_data_hold got %h want a5", data_out1); end
        checks++;
    endtask

    task automatic test_parity_error;
        int s;
        send1(8'h01, 1'b0, 1'b1, s);
        hold(20);
        if (perr_cnt1 !== 1 || wr_cnt1 !== 1) begin errors++; $display("FAIL parity_err got perr=%0d wr=%0d want perr=1 wr=1", perr_cnt1, wr_cnt1); end
        checks++;
        send1(8'h3C, 1'b0, 1'b1, s);
        hold(20);
        if (wr_cnt1 !== 2 || last_wr1 !== 8'h3C) begin errors++; $display("FAIL parity_recover got cnt=%0d data=%h want cnt=2 data=3c", wr_cnt1, last_wr1); end
        checks++;
    endtask

    task automatic test_framing;
        int s;
        send1(8'h55, 1'b0, 1'b0, s);
        hold(30);
        if (ferr_cnt1 !== 1 || perr_cnt1 !== 1 || oerr_cnt1 !== 0 || wr_cnt1 !== 2) begin
            errors++;
            $display("FAIL framing got ferr=%0d perr=%0d oerr=%0d wr=%0d want 1 1 0 2", ferr_cnt1, perr_cnt1, oerr_cnt1, wr_cnt1);
        end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL framing_idle got %b want 0", busy1); end
        checks++;
    endtask

    task automatic test_glitch;
        logic seen = 1'b0;
        line1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) line1 = 1'b1;
            if (busy1) seen = 1'b1;
        end
        if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b want 1", seen); end
        checks++;
        hold(20);
        if (busy1 !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b want 0", busy1); end
        checks++;
        if (wr_cnt1 + perr_cnt1 + ferr_cnt1 + oerr_cnt1 !== 4) begin errors++; $display("FAIL glitch_no_pulse got %0d want 4", wr_cnt1 + perr_cnt1 + ferr_cnt1 + oerr_cnt1); end
        checks++;
    endtask

    task automatic test_back_to_back;
        int s;
        send1(8'h00, 1'b0, 1'b1, s);
        fifo_full = 1'b1;
        send1(8'hFF, 1'b0, 1'b1, s);
        hold(20);
        fifo_full = 1'b0;
        if (wr_cnt1 !== 3 || last_wr1 !== 8'h00) begin errors++; $display("FAIL b2b_write got cnt=%0d data=%h want cnt=3 data=00", wr_cnt1, last_wr1); end
        checks++;
        if (oerr_cnt1 !== 1 || data_out1 !== 8'hFF) begin errors++; $display("FAIL b2b_overrun got oerr=%0d data=%h want oerr=1 data=ff", oerr_cnt1, data_out1); end
        checks++;
        if (multi1 !== 0) begin errors++; $display("FAIL pulse_exclusive got %0d want 0", multi1); end
        checks++;
    endtask

    task automatic test_no_parity;
        logic [7:0] d = 8'h7E;
        int s = cyc;
        line0 = 1'b0; hold(10);
        for (int i = 0; i < 8; i++) begin line0 = d[i]; hold(10); end
        line0 = 1'b1; hold(30);
        if (wr_cnt0 !== 1 || last_wr0 !== 8'h7E || err_cnt0 !== 0) begin
            errors++;
            $display("FAIL nopar_write got cnt=%0d data=%h err=%0d want 1 7e 0", wr_cnt0, last_wr0, err_cnt0);
        end
        checks++;
        if (wr_cyc0 - s < 96 || wr_cyc0 - s > 99) begin errors++; $display("FAIL nopar_latency got %0d want 96..99", wr_cyc0 - s); end
        checks++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d = 8'h81;
        int s;
        line1 = 1'b0; hold(10);
        for (int i = 0; i < 4; i++) begin line1 = d[i]; hold(10); end
        line1 = d[4]; hold(5);
        rst_n = 1'b0;
        #1;
        if (data_out1 !== 8'h00 || busy1 !== 1'b0 || {wr1, perr1, ferr1, oerr1} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs got data=%h busy=%b pulses=%b want 00 0 0000", data_out1, busy1, {wr1, perr1, ferr1, oerr1});
        end
        checks++;
        line1 = 1'b1;
        hold(3);
        rst_n = 1'b1;
        hold(20);
        if (wr_cnt1 + perr_cnt1 + ferr_cnt1 + oerr_cnt1 !== 6) begin errors++; $display("FAIL midreset_no_pulse got %0d want 6", wr_cnt1 + perr_cnt1 + ferr_cnt1 + oerr_cnt1); end
        checks++;
        send1(8'h81, 1'b0, 1'b1, s);
        hold(20);
        if (wr_cnt1 !== 4 || last_wr1 !== 8'h81) begin errors++; $display("FAIL midreset_recover got cnt=%0d data=%h want cnt=4 data=81", wr_cnt1, last_wr1); end
        checks++;
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_good_frame;
        test_parity_error;
        test_framing;
        test_glitch;
        test_back_to_back;
        test_no_parity;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
